// File: rtl/matrix_result_serializer.sv
// Streams nine snapshotted matrix results out as zero-padded LSB-first bytes.
// Optional trailing XOR checksum byte: define RESULT_SER_CHECKSUM_EN.
module matrix_result_serializer #(
  parameter int NUM_ELEM = 9,
  parameter int RES_W    = 18
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [NUM_ELEM*RES_W-1:0] c_flat,
  output logic [7:0]                out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done
);

  localparam int BPE = (RES_W + 7) / 8;
  localparam int EW  = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam int BW  = (BPE > 1) ? $clog2(BPE) : 1;

`ifdef RESULT_SER_CHECKSUM_EN
  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_CSUM, S_FIN
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE, S_SEND, S_FIN
  } state_t;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [RES_W-1:0]   r_snap [NUM_ELEM];
  logic [EW-1:0]      r_elem_idx;
  logic [BW-1:0]      r_byte_idx;
  logic [BPE*8-1:0]   w_pad;
  logic [7:0]         w_bytes [BPE];
  logic [7:0]         w_data;
  logic               w_xfer;
  logic               w_last;
  logic               w_elem_end;
`ifdef RESULT_SER_CHECKSUM_EN
  logic [7:0]         r_csum;
`endif

  assign w_xfer     = out_valid && out_ready;
  assign w_elem_end = (r_byte_idx == BW'(BPE - 1));
  assign w_last     = w_elem_end &&
                      (r_elem_idx == EW'(NUM_ELEM - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_SEND;
      S_SEND: begin
        if (w_xfer && w_last) begin
`ifdef RESULT_SER_CHECKSUM_EN
          w_next = S_CSUM;
`else
          w_next = S_FIN;
`endif
        end
      end
`ifdef RESULT_SER_CHECKSUM_EN
      S_CSUM: if (w_xfer) w_next = S_FIN;
`endif
      S_FIN:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ELEM; i++) r_snap[i] <= '0;
      r_elem_idx <= '0;
      r_byte_idx <= '0;
`ifdef RESULT_SER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else if (r_state == S_IDLE && start) begin
      for (int i = 0; i < NUM_ELEM; i++)
        r_snap[i] <= c_flat[i*RES_W +: RES_W];
      r_elem_idx <= '0;
      r_byte_idx <= '0;
`ifdef RESULT_SER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else if (r_state == S_SEND && w_xfer) begin
`ifdef RESULT_SER_CHECKSUM_EN
      r_csum <= r_csum ^ w_data;
`endif
      // Indices freeze on the final byte so they never leave range.
      if (!w_last) begin
        if (w_elem_end) begin
          r_byte_idx <= '0;
          r_elem_idx <= r_elem_idx + EW'(1);
        end else begin
          r_byte_idx <= r_byte_idx + BW'(1);
        end
      end
    end
  end

  always_comb begin
    w_pad = '0;
    w_pad[RES_W-1:0] = r_snap[r_elem_idx];
    for (int b = 0; b < BPE; b++)
      w_bytes[b] = w_pad[b*8 +: 8];
  end

  always_comb begin
    w_data = '0;
    unique case (r_state)
      S_SEND: w_data = w_bytes[r_byte_idx];
`ifdef RESULT_SER_CHECKSUM_EN
      S_CSUM: w_data = r_csum;
`endif
      default: w_data = '0;
    endcase
  end

  assign out_data = w_data;
`ifdef RESULT_SER_CHECKSUM_EN
  assign out_valid = (r_state == S_SEND) || (r_state == S_CSUM);
`else
  assign out_valid = (r_state == S_SEND);
`endif
  assign busy = out_valid;
  assign done = (r_state == S_FIN);

endmodule

// File: tb/tb_matrix_result_serializer.sv
// Scoreboard bench for matrix_result_serializer.
// Random and directed streams against a byte-level reference model.
module tb_matrix_result_serializer;

  localparam int NE = 9;
  localparam int RW = 18;
  localparam int BPE = 3;
`ifdef RESULT_SER_CHECKSUM_EN
  localparam int NB = NE * BPE + 1;
`else
  localparam int NB = NE * BPE;
`endif

  logic              clk = 0;
  logic              rst_n = 0;
  logic              start = 0;
  logic [NE*RW-1:0]  c_flat = '0;
  logic [7:0]        out_data;
  logic              out_valid;
  logic              out_ready = 0;
  logic              busy;
  logic              done;

  matrix_result_serializer #(.NUM_ELEM(NE), .RES_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .c_flat(c_flat),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] q[$];
  int cyc = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int last_cyc = -10;
  int done_cyc = 0;
  int s_cyc = 0;
  int rmode = 0;
  int rphase = 0;
  logic prev_stall = 0;
  logic [7:0] prev_data = 0;
  logic prev_done = 0;

  task automatic check(input string name, input logic ok,
                       input longint act, input longint exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: out_ready = 1;
      1: out_ready = ($urandom_range(0, 2) != 0);
      default: begin
        out_ready = (rphase % 3 == 0);
        rphase++;
      end
    endcase
  end

  // Monitor: decoupled from stimulus, pops the scoreboard on each transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      prev_done = 0;
    end else begin
      check("busy_eq_valid", busy == out_valid, busy, out_valid);
      if (prev_stall) begin
        check("stall_valid", out_valid, out_valid, 1);
        check("stall_data", out_data == prev_data, out_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("extra_byte", 0, out_data, 0);
        end else begin
          logic [7:0] e;
          e = q.pop_front();
          check("byte", out_data == e, out_data, e);
          if (q.size() == 0) last_cyc = cyc;
        end
        xfer_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_after_last", cyc == last_cyc + 1, cyc, last_cyc + 1);
        check("done_width", !prev_done, prev_done, 0);
      end
      prev_done = done;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  function automatic void push_expected(input logic [NE*RW-1:0] c);
    logic [7:0] x;
    x = 0;
    for (int e = 0; e < NE; e++) begin
      int unsigned v;
      v = 32'(c[e*RW +: RW]);
      for (int b = 0; b < BPE; b++) begin
        logic [7:0] by;
        by = 8'((v >> (8 * b)) & 255);
        q.push_back(by);
        x ^= by;
      end
    end
`ifdef RESULT_SER_CHECKSUM_EN
    q.push_back(x);
`endif
  endfunction

  function automatic logic [NE*RW-1:0] rand_c();
    logic [NE*RW-1:0] c;
    for (int e = 0; e < NE; e++) c[e*RW +: RW] = 18'($urandom);
    return c;
  endfunction

  task automatic start_stream(input logic [NE*RW-1:0] c);
    c_flat = c;
    push_expected(c);
    start = 1;
    @(posedge clk);
    #1;
    s_cyc = cyc;
    start = 0;
  endtask

  task automatic wait_stream(input int d0, input logic timed);
    int n;
    n = 0;
    while (!(done_cnt > d0 && q.size() == 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("stream_timeout", n < 3000, n, 3000);
    check("queue_empty", q.size() == 0, q.size(), 0);
    if (timed)
      check("stream_len", done_cyc - s_cyc == NB, done_cyc - s_cyc, NB);
  endtask

  task automatic run(input logic [NE*RW-1:0] c, input int mode);
    int d0;
    int x0;
    rmode = mode;
    rphase = 0;
    d0 = done_cnt;
    x0 = xfer_cnt;
    start_stream(c);
    wait_stream(d0, mode == 0);
    check("xfer_count", xfer_cnt - x0 == NB, xfer_cnt - x0, NB);
    check("done_once", done_cnt - d0 == 1, done_cnt - d0, 1);
  endtask

  initial begin
    logic [NE*RW-1:0] c;
    int d0;
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", out_valid == 0, out_valid, 0);
    check("rst_data", out_data == 0, out_data, 0);
    check("rst_busy", busy == 0, busy, 0);
    check("rst_done", done == 0, done, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (2) @(posedge clk);
    #1;

    c = '0;
    c[0 +: RW] = 18'h3ABCD;
    run(c, 0);

    for (int i = 0; i < 8; i++) c[i*RW +: RW] = 18'(i);
    c[8*RW +: RW] = 18'h3FFFF;
    run(c, 0);

    run(rand_c(), 2);
    for (int k = 0; k < 6; k++) run(rand_c(), k % 2);

    // start and c_flat changes mid-stream must be ignored
    rmode = 1;
    d0 = done_cnt;
    start_stream(rand_c());
    repeat (4) @(posedge clk);
    #1;
    c_flat = rand_c();
    start = 1;
    repeat (3) @(posedge clk);
    #1;
    start = 0;
    c_flat = rand_c();
    wait_stream(d0, 0);
    repeat (5) @(posedge clk);
    #1;
    check("no_restart", done_cnt - d0 == 1, done_cnt - d0, 1);
    check("idle_after", out_valid == 0, out_valid, 0);

    // start coinciding with FIN is ignored
    rmode = 0;
    d0 = done_cnt;
    start_stream(rand_c());
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("fin_seen", done, done, 1);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    repeat (3) begin
      @(negedge clk);
      check("fin_start_ignored", out_valid == 0, out_valid, 0);
    end
    @(posedge clk);
    #1;

    // reset after five transfers abandons the stream
    rmode = 0;
    d0 = xfer_cnt;
    start_stream(rand_c());
    n = 0;
    while (xfer_cnt - d0 < 5 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("five_xfers", xfer_cnt - d0 == 5, xfer_cnt - d0, 5);
    rst_n = 0;
    q.delete();
    repeat (2) begin
      @(negedge clk);
      check("rst_mid_valid", out_valid == 0, out_valid, 0);
      check("rst_mid_done", done == 0, done, 0);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk);
    #1;
    c = '0;
    c[0 +: RW] = 18'h3ABCD;
    run(c, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
